// File: rtl/ii_pkg.sv
// Shared types and default sizes for the integral image generator.
package ii_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ii_state_t;

  localparam int unsigned II_IMG_W  = 240;
  localparam int unsigned II_IMG_H  = 240;
  localparam int unsigned II_PIX_W  = 8;
  localparam int unsigned II_SUM_W  = 32;
  localparam int unsigned II_ADDR_W = 17;

endpackage

// File: rtl/ii_row_buf.sv
// Single-port row buffer holding the previous row of integral values.
// Read is combinational, so a same-cycle write at the same index returns the old value.
module ii_row_buf #(
  parameter int unsigned DEPTH = 240,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/integral_image_gen.sv
// Streaming summed-area image generator for one raster-order tile.
// Optional macro II_SAT_EN: saturating additions plus sticky sat_flag output.
module integral_image_gen
  import ii_pkg::*;
#(
  parameter int unsigned IMG_W  = II_IMG_W,
  parameter int unsigned IMG_H  = II_IMG_H,
  parameter int unsigned PIX_W  = II_PIX_W,
  parameter int unsigned SUM_W  = II_SUM_W,
  parameter int unsigned ADDR_W = II_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              frame_done
`ifdef II_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  ii_state_t state, state_nx;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [SUM_W-1:0]  row_sum;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_fire, out_fire, last_x, last_pix;
  logic [SUM_W-1:0]  pix_ext, row_base, above, rd_data, new_row, ii_val;
`ifdef II_SAT_EN
  logic [SUM_W:0]    row_wide, ii_wide;
  logic              row_sat, ii_sat;
`endif

  assign pix_ready = (state == RUN) && (!out_valid || out_ready);
  assign pix_fire  = pix_ready && pix_valid;
  assign out_fire  = out_valid && out_ready;
  assign last_x    = (x == XW'(IMG_W - 1));
  assign last_pix  = last_x && (y == YW'(IMG_H - 1));
  assign busy      = (state != IDLE);

  // Row 0 has no row above, so the buffer read is bypassed with zero.
  always_comb begin
    pix_ext  = SUM_W'(pix_data);
    row_base = (x == '0) ? '0 : row_sum;
    above    = (y == '0) ? '0 : rd_data;
`ifdef II_SAT_EN
    row_wide = {1'b0, row_base} + {1'b0, pix_ext};
    row_sat  = row_wide[SUM_W];
    new_row  = row_sat ? '1 : row_wide[SUM_W-1:0];
    ii_wide  = {1'b0, new_row} + {1'b0, above};
    ii_sat   = ii_wide[SUM_W];
    ii_val   = ii_sat ? '1 : ii_wide[SUM_W-1:0];
`else
    new_row  = row_base + pix_ext;
    ii_val   = new_row + above;
`endif
  end

  ii_row_buf #(
    .DEPTH (IMG_W),
    .WIDTH (SUM_W),
    .AW    (XW)
  ) u_row_buf (
    .clk   (clk),
    .we    (pix_fire),
    .addr  (x),
    .wdata (ii_val),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (pix_fire && last_pix) state_nx = DRAIN;
      DRAIN:   if (out_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      row_sum    <= '0;
      pix_addr   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && out_fire;
      if (state == IDLE && start) begin
        x        <= '0;
        y        <= '0;
        row_sum  <= '0;
        pix_addr <= '0;
      end
      // A new pixel reloads the output word even when the held one leaves this cycle.
      if (pix_fire) begin
        row_sum   <= new_row;
        out_data  <= ii_val;
        out_addr  <= pix_addr;
        out_valid <= 1'b1;
        pix_addr  <= pix_addr + 1'b1;
        if (last_x) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef II_SAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 sat_flag <= 1'b0;
    else if (state == IDLE && start)           sat_flag <= 1'b0;
    else if (pix_fire && (row_sat || ii_sat))  sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_integral_image_gen.sv
// Directed table-driven bench for integral_image_gen on a 4x3 tile.
// Build with II_SAT_EN to also run the 8-bit saturation frame.
module tb_integral_image_gen;

  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 3;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int          NPIX   = 12;
`ifdef II_SAT_EN
  localparam int unsigned SUM_W  = 8;
`else
  localparam int unsigned SUM_W  = 32;
`endif

  typedef struct {
    logic [7:0]  pix;
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vec [3][NPIX];
  int   e0 [NPIX] = '{1, 2, 3, 4, 2, 4, 6, 8, 3, 6, 9, 12};
  int   e1 [NPIX] = '{0, 1, 3, 6, 4, 10, 18, 28, 12, 27, 45, 66};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [SUM_W-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              frame_done;
`ifdef II_SAT_EN
  logic              sat_flag;
`endif

  int total = 0;
  int bad   = 0;

  integral_image_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .PIX_W  (PIX_W),
    .SUM_W  (SUM_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef II_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  // Output monitor: records every accepted word and frame_done pulse timing.
  logic [31:0] q_data [$];
  logic [31:0] q_addr [$];
  int cyc = 0;
  int last_hs = 0;
  int fd_cyc = -1;
  int fd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      q_data.push_back(32'(out_data));
      q_addr.push_back(32'(out_addr));
      last_hs <= cyc + 1;
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_pixel(input logic [7:0] p, input string tag);
    bit got = 0;
    pix_valid = 1'b1;
    pix_data  = p;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pix_ready) begin
        got = 1;
        break;
      end
    end
    if (got) tick();
    else check({tag, "_pix_timeout"}, 32'd0, 32'd1);
    pix_valid = 1'b0;
    pix_data  = 8'($urandom);
  endtask

  task automatic run_frame(input int pat, input int stall_at, input int start_at, input string tag);
    int base;
    int fdb;
    base = q_data.size();
    fdb  = fd_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    for (int i = 0; i < NPIX; i++) begin
      if (i == start_at) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
      end
      push_pixel(vec[pat][i].pix, tag);
      if (i == stall_at) begin
        out_ready = 1'b0;
        pix_valid = 1'b1;
        pix_data  = vec[pat][i+1].pix;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check({tag, "_stall_pix_ready"}, 32'(pix_ready), 32'd0);
          check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
          check({tag, "_stall_addr"}, 32'(out_addr), vec[pat][i].exp_addr);
          check({tag, "_stall_data"}, 32'(out_data), vec[pat][i].exp_data);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        pix_valid = 1'b0;
      end
    end
    for (int k = 0; k < 50 && busy; k++) tick();
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_word_count"}, 32'(q_data.size() - base), 32'(NPIX));
    for (int j = 0; j < NPIX; j++) begin
      if (base + j < q_data.size()) begin
        check({tag, "_addr"}, q_addr[base+j], vec[pat][j].exp_addr);
        check({tag, "_data"}, q_data[base+j], vec[pat][j].exp_data);
      end
    end
    check({tag, "_frame_done_cnt"}, 32'(fd_cnt - fdb), 32'd1);
    check({tag, "_frame_done_cyc"}, 32'(fd_cyc), 32'(last_hs));
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      vec[0][i].pix = 8'd1;
      vec[0][i].exp_data = 32'(e0[i]);
      vec[0][i].exp_addr = 32'(i);
      vec[1][i].pix = 8'(i);
      vec[1][i].exp_data = 32'(e1[i]);
      vec[1][i].exp_addr = 32'(i);
      vec[2][i].pix = 8'd255;
      vec[2][i].exp_data = 32'd255;
      vec[2][i].exp_addr = 32'(i);
    end

    tick();
    tick();
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_pix_ready", 32'(pix_ready), 32'd0);

    run_frame(0, -1, -1, "ones");
`ifdef II_SAT_EN
    check("ones_sat_flag", 32'(sat_flag), 32'd0);
`endif
    run_frame(1, 4, -1, "ramp_stall");

    // Abort a frame after 5 pixels, then rerun with a stray start mid-frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) push_pixel(8'd1, "abort");
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_pix_ready", 32'(pix_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_frame(0, -1, 6, "after_reset");

`ifdef II_SAT_EN
    run_frame(2, -1, -1, "sat");
    check("sat_flag", 32'(sat_flag), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
